// File: rtl/msp_mem_pkg.sv
// Shared memory-map definitions for the data RAM path: FSM and owner
// encodings, RAM window bounds, and the latched request record.
package msp_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT_WD = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam logic [15:0] RAM_BOUND_L = 16'h0200;
  localparam logic [15:0] RAM_BOUND_U = 16'h0400;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] din;
    logic        rw;
    logic        bw;
  } mem_req_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter; one instance per requester.
// Handshake: the requester raises req with addr/din/rw/bw stable and keeps
// them until it sees ack (one cycle, err/dout valid with it); it must drop or
// change req in that ack cycle, since a req still high afterwards is a new
// transaction.
interface ram_arbiter_if;
  logic        req;
  logic [15:0] addr;
  logic [15:0] din;
  logic        rw;
  logic        bw;
  logic        ack;
  logic        err;
  logic [15:0] dout;

  modport master (output req, addr, din, rw, bw, input ack, err, dout);
  modport slave  (input req, addr, din, rw, bw, output ack, err, dout);
endinterface

// File: rtl/ram_addr_check.sv
// Combinational range/alignment check of an absolute byte address against a
// RAM window, plus translation to the window-relative index.
module ram_addr_check
  import msp_mem_pkg::*;
#(
  parameter logic [15:0] BOUND_L = RAM_BOUND_L,
  parameter logic [15:0] BOUND_U = RAM_BOUND_U
) (
  input  logic [15:0] addr,
  input  logic        bw,
  output logic        err,
  output logic [15:0] idx
);

  always_comb begin
    err = 1'b0;
    if (addr < BOUND_L || addr >= BOUND_U) err = 1'b1;
    // A word access needs an even address and a second byte inside the window.
    if (!bw && (addr[0] || addr == BOUND_U - 16'd1)) err = 1'b1;
    idx = addr - BOUND_L;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU and DMA requesters: grants,
// checks, drives the RAM for one transaction at a time and acks the owner.
module ram_arbiter
  import msp_mem_pkg::*;
#(
  parameter logic [15:0] BOUND_L    = RAM_BOUND_L,
  parameter logic [15:0] BOUND_U    = RAM_BOUND_U,
  parameter int          MAX_HOLD   = 4,
  parameter int          WD_TIMEOUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  cpu,
  ram_arbiter_if.slave  dma,
  output logic [15:0]   ram_addr,
  output logic [15:0]   ram_Din,
  output logic          ram_RW,
  output logic          BW,
  input  logic          ram_write_done,
  input  logic [15:0]   ram_out,
  output state_t        dbg_state,
  output owner_t        dbg_owner
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int WW = $clog2(WD_TIMEOUT + 1);

  state_t      state;
  state_t      state_nx;
  owner_t      owner;
  logic [HW-1:0] hold_cnt;
  logic [WW-1:0] wd_cnt;
  mem_req_t    lat;
  logic        resp_err;
  logic [15:0] addr_q;
  logic [15:0] din_q;
  logic        bw_q;
  logic [15:0] cpu_dout_q;
  logic [15:0] dma_dout_q;

  logic        chk_err;
  logic [15:0] chk_idx;
  logic        grant_cpu;
  logic        grant_dma;
  logic        ram_act;
  logic        wd_expired;
  logic [15:0] rd_data;

  ram_addr_check #(
    .BOUND_L (BOUND_L),
    .BOUND_U (BOUND_U)
  ) u_check (
    .addr (lat.addr),
    .bw   (lat.bw),
    .err  (chk_err),
    .idx  (chk_idx)
  );

  always_comb begin
    grant_cpu  = cpu.req && !(dma.req && hold_cnt == HW'(MAX_HOLD));
    grant_dma  = !grant_cpu && dma.req;
    ram_act    = (state == ACCESS) && !chk_err;
    wd_expired = (state == WAIT_WD) && !ram_write_done &&
                 (wd_cnt == WW'(WD_TIMEOUT - 1));
    rd_data    = lat.bw ? {8'h00, ram_out[7:0]} : ram_out;
    state_nx   = state;
    case (state)
      IDLE:    if (grant_cpu || grant_dma) state_nx = ACCESS;
      ACCESS:  state_nx = (ram_act && lat.rw) ? WAIT_WD : RESP;
      WAIT_WD: if (ram_write_done || wd_expired) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      hold_cnt   <= '0;
      wd_cnt     <= '0;
      lat        <= '0;
      resp_err   <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      bw_q       <= 1'b0;
      cpu_dout_q <= '0;
      dma_dout_q <= '0;
    end else begin
      state <= state_nx;
      if (!dma.req) hold_cnt <= '0;
      case (state)
        IDLE: begin
          if (grant_cpu) begin
            owner <= OWN_CPU;
            lat   <= '{addr: cpu.addr, din: cpu.din, rw: cpu.rw, bw: cpu.bw};
            // A CPU grant with dma pending implies hold_cnt < MAX_HOLD, so this saturates.
            if (dma.req) hold_cnt <= hold_cnt + HW'(1);
          end else if (grant_dma) begin
            owner    <= OWN_DMA;
            lat      <= '{addr: dma.addr, din: dma.din, rw: dma.rw, bw: dma.bw};
            hold_cnt <= '0;
          end
        end
        ACCESS: begin
          resp_err <= chk_err;
          wd_cnt   <= '0;
          if (ram_act) begin
            addr_q <= chk_idx;
            din_q  <= lat.din;
            bw_q   <= lat.bw;
            if (!lat.rw) begin
              if (owner == OWN_CPU) cpu_dout_q <= rd_data;
              else                  dma_dout_q <= rd_data;
            end
          end
        end
        WAIT_WD: begin
          wd_cnt <= wd_cnt + WW'(1);
          if (wd_expired) resp_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // RAM lines show the live request in ACCESS and otherwise hold the last one.
  assign ram_addr = ram_act ? chk_idx : addr_q;
  assign ram_Din  = ram_act ? lat.din : din_q;
  assign BW       = ram_act ? lat.bw  : bw_q;
  assign ram_RW   = ram_act && lat.rw;

  assign cpu.ack  = (state == RESP) && (owner == OWN_CPU);
  assign dma.ack  = (state == RESP) && (owner == OWN_DMA);
  assign cpu.err  = cpu.ack && resp_err;
  assign dma.err  = dma.ack && resp_err;
  assign cpu.dout = cpu_dout_q;
  assign dma.dout = dma_dout_q;

  assign dbg_state = state;
  assign dbg_owner = owner;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, arbitration,
// watchdog and reset sequences, then random traffic against a byte-map model.
module tb_ram_arbiter;
  import msp_mem_pkg::*;

  localparam int W = 28;

  logic        clk;
  logic        rst;
  logic [15:0] ram_addr;
  logic [15:0] ram_Din;
  logic        ram_RW;
  logic        BW;
  logic        ram_write_done;
  logic [15:0] ram_out;
  state_t      dbg_state;
  owner_t      dbg_owner;
  logic        done_en;

  ram_arbiter_if cpu_if ();
  ram_arbiter_if dma_if ();

  ram_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .cpu            (cpu_if),
    .dma            (dma_if),
    .ram_addr       (ram_addr),
    .ram_Din        (ram_Din),
    .ram_RW         (ram_RW),
    .BW             (BW),
    .ram_write_done (ram_write_done),
    .ram_out        (ram_out),
    .dbg_state      (dbg_state),
    .dbg_owner      (dbg_owner)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- RAM stub ----------------
  logic [7:0] mem [0:511];
  assign ram_out = {mem[ram_addr[8:0] + 9'd1], mem[ram_addr[8:0]]};

  always @(posedge clk) begin
    if (rst) ram_write_done <= 1'b0;
    else     ram_write_done <= ram_RW && done_en;
    if (ram_RW) begin
      mem[ram_addr[8:0]] <= ram_Din[7:0];
      if (!BW) mem[ram_addr[8:0] + 9'd1] <= ram_Din[15:8];
    end
  end

  // ---------------- monitors ----------------
  int          rw_pulses = 0;
  logic [15:0] rw_addr;
  logic        rw_bw;
  int          cpu_ack_cnt = 0;
  int          dma_ack_cnt = 0;
  int          both_ack_cnt = 0;

  always @(negedge clk) begin
    if (ram_RW) begin
      rw_pulses++;
      rw_addr = ram_addr;
      rw_bw   = BW;
    end
    if (cpu_if.ack) cpu_ack_cnt++;
    if (dma_if.ack) dma_ack_cnt++;
    if (cpu_if.ack && dma_if.ack) both_ack_cnt++;
  end

  // ---------------- scoreboard / reference model ----------------
  int n_pass = 0;
  int n_total = 0;
  int exp_cpu_acks = 0;
  int exp_dma_acks = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] ref_mem [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Byte-addressed view of the RAM window keyed by absolute address.
  function automatic void model(input logic [15:0] a, input logic [15:0] d,
                                input logic rw, input logic bw,
                                output logic err, output logic known,
                                output logic [15:0] dout);
    int ai;
    ai    = int'(a);
    err   = (ai < 'h200) || (ai >= 'h400) || (!bw && ((ai % 2) == 1 || ai == 'h3FF));
    known = 1'b0;
    dout  = 16'h0;
    if (!err) begin
      if (rw) begin
        ref_mem[ai] = d[7:0];
        if (!bw) ref_mem[ai + 1] = d[15:8];
      end else if (bw) begin
        known = ref_mem.exists(ai);
        if (known) dout = {8'h00, ref_mem[ai]};
      end else begin
        known = ref_mem.exists(ai) && ref_mem.exists(ai + 1);
        if (known) dout = {ref_mem[ai + 1], ref_mem[ai]};
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input bit who, input logic [15:0] a, input logic [15:0] d,
                           input logic rw, input logic bw);
    if (who) begin
      dma_if.addr = a; dma_if.din = d; dma_if.rw = rw; dma_if.bw = bw; dma_if.req = 1'b1;
    end else begin
      cpu_if.addr = a; cpu_if.din = d; cpu_if.rw = rw; cpu_if.bw = bw; cpu_if.req = 1'b1;
    end
  endtask

  task automatic run_txn(input bit who, input logic [15:0] a, input logic [15:0] d,
                         input logic rw, input logic bw,
                         output logic err, output logic [15:0] dout,
                         output int lat, output int pulses);
    int  p0;
    bit  seen;
    @(negedge clk);
    drive_req(who, a, d, rw, bw);
    if (who) exp_dma_acks++;
    else     exp_cpu_acks++;
    p0 = rw_pulses; lat = 0; seen = 1'b0; err = 1'b0; dout = 16'h0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (who ? dma_if.ack : cpu_if.ack) begin
        seen = 1'b1;
        err  = who ? dma_if.err : cpu_if.err;
        dout = who ? dma_if.dout : cpu_if.dout;
      end
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
    if (who) dma_if.req = 1'b0;
    else     cpu_if.req = 1'b0;
    pulses = rw_pulses - p0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          who;
    logic [15:0] addr;
    logic [15:0] din;
    logic        rw;
    logic        bw;
    logic        exp_err;
    logic        chk_dout;
    logic [15:0] exp_dout;
    int          exp_lat;
    int          exp_pulses;
    logic [15:0] exp_ram_addr;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic        err, known, e_err;
    logic [15:0] dout, e_dout, a, d;
    logic        rw, bw;
    int          lat, pulses, e_lat, e_p;
    bit          who;
    logic [W-1:0] exp;
    bit          exp_owner[10];
    int          got, cyc;

    cpu_if.req = 1'b0; cpu_if.addr = '0; cpu_if.din = '0; cpu_if.rw = 1'b0; cpu_if.bw = 1'b0;
    dma_if.req = 1'b0; dma_if.addr = '0; dma_if.din = '0; dma_if.rw = 1'b0; dma_if.bw = 1'b0;
    done_en = 1'b1;

    //        who   addr      din      rw    bw    err   chkd  dout     lat p  ram_addr
    vecs[0]  = '{1'b0, 16'h0210, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 1, 16'h0010};
    vecs[1]  = '{1'b0, 16'h0210, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 2, 0, 16'h0000};
    vecs[2]  = '{1'b0, 16'h0211, 16'h00AB, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3, 1, 16'h0011};
    vecs[3]  = '{1'b0, 16'h0211, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00AB, 2, 0, 16'h0000};
    vecs[4]  = '{1'b0, 16'h0210, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAB34, 2, 0, 16'h0000};
    vecs[5]  = '{1'b0, 16'h0201, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2, 0, 16'h0000};
    vecs[6]  = '{1'b0, 16'h01FE, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2, 0, 16'h0000};
    vecs[7]  = '{1'b0, 16'h03FF, 16'h9999, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 2, 0, 16'h0000};
    vecs[8]  = '{1'b0, 16'h0400, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2, 0, 16'h0000};
    vecs[9]  = '{1'b0, 16'h03FF, 16'h005A, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 3, 1, 16'h01FF};
    vecs[10] = '{1'b0, 16'h03FF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h005A, 2, 0, 16'h0000};
    vecs[11] = '{1'b1, 16'h03FE, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 1, 16'h01FE};
    vecs[12] = '{1'b1, 16'h03FE, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 2, 0, 16'h0000};
    vecs[13] = '{1'b1, 16'h0400, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2, 0, 16'h0000};
    vecs[14] = '{1'b0, 16'h01FF, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2, 0, 16'h0000};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state",   32'(dbg_state), 32'(IDLE));
    check("rst_owner",   32'(dbg_owner), 32'(OWN_CPU));
    check("rst_outputs", {cpu_if.ack, cpu_if.err, dma_if.ack, dma_if.err, ram_RW, BW},
                         32'd0);
    check("rst_douts",   {cpu_if.dout, dma_if.dout}, 32'd0);
    check("rst_ram_bus", {ram_addr, ram_Din}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_txn(vecs[i].who, vecs[i].addr, vecs[i].din, vecs[i].rw, vecs[i].bw,
              err, dout, lat, pulses);
      model(vecs[i].addr, vecs[i].din, vecs[i].rw, vecs[i].bw, e_err, known, e_dout);
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rw_pulses", i), pulses, vecs[i].exp_pulses);
      if (vecs[i].exp_pulses != 0) begin
        check($sformatf("v%0d_ram_addr", i), 32'(rw_addr), 32'(vecs[i].exp_ram_addr));
        check($sformatf("v%0d_bw", i), 32'(rw_bw), 32'(vecs[i].bw));
      end
      if (vecs[i].chk_dout)
        check($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
    end

    // Both requesters held high: four CPU grants, then DMA is forced.
    exp_owner = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    drive_req(1'b0, 16'h0210, 16'h0000, 1'b0, 1'b0);
    drive_req(1'b1, 16'h0212, 16'h0000, 1'b0, 1'b0);
    exp_cpu_acks += 8;
    exp_dma_acks += 2;
    got = 0; cyc = 0;
    while (got < 10 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cpu_if.ack || dma_if.ack) begin
        check($sformatf("grant%0d_is_dma", got), 32'(dma_if.ack), 32'(exp_owner[got]));
        got++;
      end
    end
    if (got < 10) check("arb_timeout", got, 10);
    cpu_if.req = 1'b0;
    dma_if.req = 1'b0;

    // DMA alone: every grant goes to DMA.
    @(negedge clk);
    drive_req(1'b1, 16'h0210, 16'h0000, 1'b0, 1'b0);
    exp_dma_acks += 5;
    got = 0; cyc = 0;
    while (got < 5 && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cpu_if.ack || dma_if.ack) begin
        check($sformatf("dma_only%0d_acks", got), {cpu_if.ack, dma_if.ack}, 32'b01);
        check($sformatf("dma_only%0d_dout", got), 32'(dma_if.dout), 32'hAB34);
        got++;
      end
    end
    if (got < 5) check("dma_only_timeout", got, 5);
    dma_if.req = 1'b0;

    // Watchdog: write-done never arrives, the write is aborted with error.
    done_en = 1'b0;
    run_txn(1'b0, 16'h0240, 16'h5555, 1'b1, 1'b0, err, dout, lat, pulses);
    model(16'h0240, 16'h5555, 1'b1, 1'b0, e_err, known, e_dout);
    check("wd_err", 32'(err), 32'd1);
    check("wd_lat", lat, 2 + 4);
    check("wd_rw_pulses", pulses, 1);
    done_en = 1'b1;
    run_txn(1'b0, 16'h0210, 16'h0000, 1'b0, 1'b0, err, dout, lat, pulses);
    check("post_wd_err", 32'(err), 32'd0);
    check("post_wd_lat", lat, 2);
    check("post_wd_dout", 32'(dout), 32'hAB34);

    // Reset while waiting for write completion.
    done_en = 1'b0;
    @(negedge clk);
    drive_req(1'b0, 16'h0230, 16'h7777, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_state", 32'(dbg_state), 32'(WAIT_WD));
    cpu_if.req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    check("mid_rst_outputs", {cpu_if.ack, cpu_if.err, dma_if.ack, dma_if.err, ram_RW, BW},
                             32'd0);
    check("mid_rst_douts", {cpu_if.dout, dma_if.dout}, 32'd0);
    check("mid_rst_ram_bus", {ram_addr, ram_Din}, 32'd0);
    rst = 1'b0;
    done_en = 1'b1;
    model(16'h0230, 16'h7777, 1'b1, 1'b0, e_err, known, e_dout);
    run_txn(1'b0, 16'h0230, 16'h0000, 1'b0, 1'b0, err, dout, lat, pulses);
    check("post_rst_err", 32'(err), 32'd0);
    check("post_rst_lat", lat, 2);
    check("post_rst_dout", 32'(dout), 32'h7777);

    // Random traffic from either requester against the byte-map model.
    for (int i = 0; i < 80; i++) begin
      who = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) a = 16'h0200 + 16'($urandom_range(0, 31));
      else                           a = 16'h01F8 + 16'($urandom_range(0, 'h210));
      d  = 16'($urandom);
      rw = 1'($urandom_range(0, 1));
      bw = 1'($urandom_range(0, 1));
      model(a, d, rw, bw, e_err, known, e_dout);
      e_lat = e_err ? 2 : (rw ? 3 : 2);
      e_p   = (!e_err && rw) ? 1 : 0;
      exp_q.push_back({e_err, known, e_dout, 8'(e_lat), 2'(e_p)});
      run_txn(who, a, d, rw, bw, err, dout, lat, pulses);
      exp = exp_q.pop_front();
      check($sformatf("rnd%0d_err a=%0h", i, a), 32'(err), 32'(exp[27]));
      check($sformatf("rnd%0d_lat a=%0h", i, a), lat, 32'(exp[9:2]));
      check($sformatf("rnd%0d_rw_pulses a=%0h", i, a), pulses, 32'(exp[1:0]));
      if (exp[26] && !exp[27] && !rw)
        check($sformatf("rnd%0d_dout a=%0h", i, a), 32'(dout), 32'(exp[25:10]));
    end

    @(negedge clk);
    check("cpu_ack_count", cpu_ack_cnt, exp_cpu_acks);
    check("dma_ack_count", dma_ack_cnt, exp_dma_acks);
    check("both_acks_same_cycle", both_ack_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
